// File: rtl/mealy.sv
// Overlapping Mealy detector for the serial pattern "1011".
// out is combinational: high while the current bit completes the pattern.
module mealy (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // S3 keeps overlap: a trailing "1" restarts at S1, "10" resumes at S2
    always_comb begin
        state_next = S0;
        case (state)
            S0:      state_next = in ? S1 : S0;
            S1:      state_next = in ? S1 : S2;
            S2:      state_next = in ? S3 : S0;
            S3:      state_next = in ? S1 : S2;
            default: state_next = S0;
        endcase
    end

    always_comb begin
        out = 1'b0;
        if (state == S3 && in) begin
            out = 1'b1;
        end
    end

endmodule

// File: tb/tb_mealy.sv
// Directed bench for the "1011" Mealy detector.
// Expected outputs and states are hand-computed per bit.
module tb_mealy;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in  = 1'b0;
    logic out;

    int checks = 0;
    int errors = 0;

    mealy dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one bit mid-cycle, check out before the edge, state after it
    task automatic step(input string tag, input int k, input logic b,
                        input logic eo, input logic [1:0] es);
        @(negedge clk);
        in = b;
        #1;
        chk($sformatf("%s_out%0d", tag, k), {1'b0, out}, {1'b0, eo});
        @(posedge clk);
        #1;
        chk($sformatf("%s_st%0d", tag, k), dut.state, es);
    endtask

    // Vectors are written first-bit-leftmost; states are 2-bit pairs
    task automatic seq(input string tag, input int n, input logic [15:0] b,
                       input logic [15:0] o, input logic [31:0] s);
        for (int i = 0; i < n; i++) begin
            step(tag, i + 1, b[n-1-i], o[n-1-i], s[2*(n-1-i) +: 2]);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        in  = 1'b0;
        #1;
        chk({tag, "_rst"}, dut.state, 2'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Reset held for the whole sequence
        rst = 1'b0;
        #1;
        chk("por_state", dut.state, 2'd0);
        chk("por_out", {1'b0, out}, 2'd0);
        seq("hold", 7, 16'b1011011, 16'b0000000,
            {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
        @(negedge clk);
        rst = 1'b1;

        seq("basic", 4, 16'b1011, 16'b0001,
            {2'd1, 2'd2, 2'd3, 2'd1});
        step("basic_after", 5, 1'b0, 1'b0, 2'd2);

        do_reset("ovl");
        seq("ovl", 9, 16'b101101101, 16'b000100100,
            {2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3});

        do_reset("near");
        seq("near", 6, 16'b101011, 16'b000001,
            {2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1});

        // Asynchronous reset while sitting in S3 with in high
        do_reset("mid");
        seq("mid", 3, 16'b101, 16'b000, {2'd1, 2'd2, 2'd3});
        @(negedge clk);
        in = 1'b1;
        #1;
        chk("mid_pre_out", {1'b0, out}, 2'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_async_st", dut.state, 2'd0);
        chk("mid_async_out", {1'b0, out}, 2'd0);
        @(posedge clk);
        #1;
        chk("mid_hold_st", dut.state, 2'd0);
        chk("mid_hold_out", {1'b0, out}, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        step("mid_rel", 1, 1'b1, 1'b0, 2'd1);

        do_reset("zeros");
        seq("zeros", 8, 16'b00000000, 16'b00000000,
            {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
        seq("ones", 8, 16'b11111111, 16'b00000000,
            {2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
